// File: rtl/dsp_pkg.sv
// Shared NCO/cordic definitions: scheduler state encoding, phase-turn size and tuning constants.
package dsp_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  // 2**TurnBits phase units make one full turn of the oscillator.
  localparam int unsigned TurnBits = 32;

  localparam logic [TurnBits-1:0] Inc440Hz48k = 32'h0258BF25;

endpackage

// File: rtl/phase_bank.sv
// Per-channel phase accumulators and phase increments.
// A clear beats an update of the same channel; an update always adds the old increment.
module phase_bank import dsp_pkg::*; #(
  parameter int unsigned WIDTH    = TurnBits,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_BITS  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               clr,
  input  logic [CH_BITS-1:0] cfg_ch,
  input  logic [WIDTH-1:0]   cfg_inc,
  input  logic               upd,
  input  logic [CH_BITS-1:0] upd_ch,
  input  logic [CH_BITS-1:0] rd_ch,
  output logic [WIDTH-1:0]   rd_phase
);

  logic [WIDTH-1:0] phase_q [CHANNELS];
  logic [WIDTH-1:0] inc_q   [CHANNELS];

  // Addresses >= CHANNELS match no entry and are thereby ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (we && cfg_ch == CH_BITS'(i)) begin
          inc_q[i] <= cfg_inc;
        end
        if (clr && cfg_ch == CH_BITS'(i)) begin
          phase_q[i] <= '0;
        end else if (upd && upd_ch == CH_BITS'(i)) begin
          phase_q[i] <= phase_q[i] + inc_q[i];
        end
      end
    end
  end

  assign rd_phase = phase_q[rd_ch];

endmodule

// File: rtl/cordic_nco_sched.sv
// Shares one external rotation-mode cordic among CHANNELS oscillators, one sweep per
// sample_tick, and streams (ch, cos, sin) out over valid/ready.
module cordic_nco_sched import dsp_pkg::*; #(
  parameter int unsigned     WIDTH          = TurnBits,
  parameter int unsigned     CHANNELS       = 4,
  parameter int unsigned     CH_BITS        = 2,
  parameter int unsigned     CORDIC_LATENCY = 0,
  parameter logic [WIDTH-1:0] AMPLITUDE     = WIDTH'(32'h40000000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [CH_BITS-1:0] cfg_ch,
  input  logic [WIDTH-1:0]   cfg_inc,
  input  logic               cfg_clr,
  output logic [WIDTH-1:0]   cor_x0,
  output logic [WIDTH-1:0]   cor_y0,
  output logic [WIDTH-1:0]   cor_z0,
  input  logic [WIDTH-1:0]   cor_xn,
  input  logic [WIDTH-1:0]   cor_yn,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CH_BITS-1:0] m_ch,
  output logic [WIDTH-1:0]   m_cos,
  output logic [WIDTH-1:0]   m_sin,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned WcntBits = (CORDIC_LATENCY < 1) ? 1 : $clog2(CORDIC_LATENCY + 1);

  state_e              state;
  logic [CH_BITS-1:0]  ch;
  logic [WcntBits-1:0] wcnt;
  logic [WIDTH-1:0]    rd_phase;
  logic                upd;
  logic                last_ch;

  assign cor_x0  = AMPLITUDE;
  assign cor_y0  = '0;
  assign last_ch = (ch == CH_BITS'(CHANNELS - 1));
  // The accumulator advances exactly when the result of its channel is accepted.
  assign upd     = (state == StOut) && m_valid && m_ready;

  phase_bank #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CH_BITS  (CH_BITS)
  ) u_phase_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_we),
    .clr      (cfg_clr),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .upd      (upd),
    .upd_ch   (ch),
    .rd_ch    (ch),
    .rd_phase (rd_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      ch      <= '0;
      wcnt    <= '0;
      cor_z0  <= '0;
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_cos   <= '0;
      m_sin   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // busy is already high in the cycle after an accepted tick, so that tick counts too.
      if (sample_tick && busy) begin
        overrun <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (sample_tick) begin
            ch    <= '0;
            busy  <= 1'b1;
            state <= StIssue;
          end
        end
        StIssue: begin
          cor_z0 <= rd_phase;
          wcnt   <= WcntBits'(CORDIC_LATENCY);
          state  <= StWait;
        end
        StWait: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WcntBits'(1);
          end else begin
            m_cos   <= cor_xn;
            m_sin   <= cor_yn;
            m_ch    <= ch;
            m_valid <= 1'b1;
            state   <= StOut;
          end
        end
        StOut: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            if (last_ch) begin
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              ch    <= ch + CH_BITS'(1);
              state <= StIssue;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_sched.sv
// Directed bench for cordic_nco_sched with a combinational stand-in cordic whose outputs
// encode the phase: x_n = z_0 + 32'h10000000, y_n = ~z_0.
module tb_cordic_nco_sched;

  localparam logic [31:0] CosOff = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst, sample_tick, cfg_we, cfg_clr, m_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [31:0] cor_x0, cor_y0, cor_z0, cor_xn, cor_yn, m_cos, m_sin;
  logic        m_valid, busy, overrun;
  logic [1:0]  m_ch;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign cor_xn = cor_z0 + CosOff;
  assign cor_yn = ~cor_z0;

  cordic_nco_sched dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_inc     (cfg_inc),
    .cfg_clr     (cfg_clr),
    .cor_x0      (cor_x0),
    .cor_y0      (cor_y0),
    .cor_z0      (cor_z0),
    .cor_xn      (cor_xn),
    .cor_yn      (cor_yn),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_ch        (m_ch),
    .m_cos       (m_cos),
    .m_sin       (m_sin),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_inc(input logic [1:0] ch, input logic [31:0] inc);
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Returns at the negedge where m_valid is seen, without consuming the result.
  task automatic collect(input logic [1:0] ch, input logic [31:0] ph);
    int n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", {31'd0, m_valid}, 32'd1);
    chk("m_ch", {30'd0, m_ch}, {30'd0, ch});
    chk("m_cos", m_cos, ph + CosOff);
    chk("m_sin", m_sin, ~ph);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic sweep(input logic [31:0] p0, p1, p2, p3);
    tick();
    collect(2'd0, p0); @(negedge clk);
    collect(2'd1, p1); @(negedge clk);
    collect(2'd2, p2); @(negedge clk);
    collect(2'd3, p3); @(negedge clk);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          busy_cnt;
    int          first_valid;
    int          idx;
    logic [1:0]  seen [4];
    int          nseen;
    int          extra;

    rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_clr = 1'b0;
    cfg_ch = '0; cfg_inc = '0; m_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset values
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_m_ch", {30'd0, m_ch}, 32'd0);
    chk("rst_m_cos", m_cos, 32'd0);
    chk("rst_m_sin", m_sin, 32'd0);
    chk("rst_cor_z0", cor_z0, 32'd0);
    chk("cor_x0", cor_x0, 32'h4000_0000);
    chk("cor_y0", cor_y0, 32'd0);

    // 1: 440 Hz increment on ch0, three samples
    set_inc(2'd0, 32'h0258BF25);
    sweep(32'h0, 32'h0, 32'h0, 32'h0);
    sweep(32'h0258BF25, 32'h0, 32'h0, 32'h0);
    sweep(32'h04B17E4A, 32'h0, 32'h0, 32'h0);

    // 2: incs 1..4, channel order, latency and sweep length
    do_reset();
    set_inc(2'd0, 32'd1); set_inc(2'd1, 32'd2); set_inc(2'd2, 32'd3); set_inc(2'd3, 32'd4);
    tick();
    busy_cnt = 0; first_valid = -1; idx = 0; nseen = 0;
    while (busy && idx < 60) begin
      busy_cnt++;
      if (m_valid) begin
        if (first_valid < 0) first_valid = idx;
        if (nseen < 4) seen[nseen] = m_ch;
        nseen++;
      end
      @(negedge clk);
      idx++;
    end
    chk("busy_clocks", busy_cnt, 32'd12);
    chk("first_valid_latency", first_valid, 32'd2);
    chk("n_results", nseen, 32'd4);
    for (int i = 0; i < 4; i++) chk("m_ch_seq", {30'd0, seen[i]}, i);
    sweep(32'd1, 32'd2, 32'd3, 32'd4);

    // 3: backpressure on ch1
    m_ready = 1'b0;
    tick();
    collect(2'd0, 32'd2);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    collect(2'd1, 32'd4);
    repeat (10) @(negedge clk);
    chk("stall_valid", {31'd0, m_valid}, 32'd1);
    chk("stall_m_ch", {30'd0, m_ch}, 32'd1);
    chk("stall_m_cos", m_cos, 32'd4 + CosOff);
    chk("stall_m_sin", m_sin, ~32'd4);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    collect(2'd2, 32'd6); @(negedge clk);
    collect(2'd3, 32'd8); @(negedge clk);
    wait_idle();
    sweep(32'd3, 32'd6, 32'd9, 32'd12);

    // 4: tick while busy
    sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b0;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    collect(2'd0, 32'd4); @(negedge clk);
    collect(2'd1, 32'd8); @(negedge clk);
    collect(2'd2, 32'd12); @(negedge clk);
    collect(2'd3, 32'd16); @(negedge clk);
    wait_idle();
    extra = 0;
    repeat (20) begin
      if (m_valid || busy) extra++;
      @(negedge clk);
    end
    chk("dropped_tick", extra, 32'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    sweep(32'd5, 32'd10, 32'd15, 32'd20);
    chk("overrun_still", {31'd0, overrun}, 32'd1);

    // 5: wrap and collisions on ch0
    do_reset();
    set_inc(2'd0, 32'hFFFF_FFF0);
    sweep(32'h0, 32'h0, 32'h0, 32'h0);
    set_inc(2'd0, 32'h20);
    sweep(32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0);
    tick();
    collect(2'd0, 32'h10);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 32'h100;
    @(negedge clk);
    cfg_we = 1'b0;
    collect(2'd1, 32'h0); @(negedge clk);
    collect(2'd2, 32'h0); @(negedge clk);
    collect(2'd3, 32'h0); @(negedge clk);
    wait_idle();
    tick();
    collect(2'd0, 32'h30);
    cfg_clr = 1'b1; cfg_ch = 2'd0;
    @(negedge clk);
    cfg_clr = 1'b0;
    collect(2'd1, 32'h0); @(negedge clk);
    collect(2'd2, 32'h0); @(negedge clk);
    collect(2'd3, 32'h0); @(negedge clk);
    wait_idle();
    sweep(32'h0, 32'h0, 32'h0, 32'h0);

    // 6: reset during WAIT (ch0 phase is 0x100 here)
    tick();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cor_z0", cor_z0, 32'd0);
    chk("mid_rst_m_cos", m_cos, 32'd0);
    chk("mid_rst_m_sin", m_sin, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    sweep(32'h0, 32'h0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
